// File: rtl/pipe_phy_ctrl_responder.sv
// PIPE PHY-side control responder: answers MAC reset, rate, power-down and
// receiver-detect requests with PhyStatus / RxStatus / PclkChangeOk handshakes.
module pipe_phy_ctrl_responder #(
  parameter int LANESNUMBER   = 16,
  parameter int RESET_CYCLES  = 8,
  parameter int RATE_CYCLES   = 12,
  parameter int PD_CYCLES     = 4,
  parameter int DETECT_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     phy_reset,
  input  logic [3:0]               Rate,
  input  logic [3:0]               PowerDown,
  input  logic                     TxDetectRx_Loopback,
  input  logic                     PclkChangeAck,
  input  logic [LANESNUMBER-1:0]   rx_present_mask,
  output logic [LANESNUMBER-1:0]   PhyStatus,
  output logic [3*LANESNUMBER-1:0] RxStatus,
  output logic                     PclkChangeOk,
  output logic [3:0]               cur_rate,
  output logic [3:0]               cur_powerdown,
  output logic                     busy
);

  localparam int MAX_AB     = (RESET_CYCLES > RATE_CYCLES) ? RESET_CYCLES : RATE_CYCLES;
  localparam int MAX_CD     = (PD_CYCLES > DETECT_CYCLES) ? PD_CYCLES : DETECT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [3:0] PD_P1 = 4'd2;

  typedef enum logic [2:0] {
    RST_WAIT,
    IDLE,
    RATE_WAIT,
    RATE_OK,
    PD_WAIT,
    DET_WAIT
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         counter_q, counter_d;
  logic [LANESNUMBER-1:0]   phy_status_q, phy_status_d;
  logic [3*LANESNUMBER-1:0] rx_status_q, rx_status_d;
  logic                     pclk_ok_q, pclk_ok_d;
  logic [3:0]               cur_rate_q, cur_rate_d;
  logic [3:0]               cur_pd_q, cur_pd_d;
  logic                     detect_pending_q, detect_pending_d;
  logic                     det_q, det_d;

  logic                     rst_done, rate_done, pd_done, det_done, det_edge;
  logic [3*LANESNUMBER-1:0] rx_result;

  assign rst_done  = (state_q == RST_WAIT)  && (counter_q == CNT_W'(RESET_CYCLES - 1));
  assign rate_done = (state_q == RATE_WAIT) && (counter_q == CNT_W'(RATE_CYCLES - 1));
  assign pd_done   = (state_q == PD_WAIT)   && (counter_q == CNT_W'(PD_CYCLES - 1));
  assign det_done  = (state_q == DET_WAIT)  && (counter_q == CNT_W'(DETECT_CYCLES - 1));
  assign det_edge  = TxDetectRx_Loopback && !det_q;

  always_comb begin
    rx_result = '0;
    for (int i = 0; i < LANESNUMBER; i++) begin
      rx_result[3*i +: 3] = rx_present_mask[i] ? 3'b011 : 3'b000;
    end
  end

  always_ff @(posedge CLK or posedge phy_reset) begin
    if (phy_reset) begin
      state_q          <= RST_WAIT;
      counter_q        <= '0;
      phy_status_q     <= '1;
      rx_status_q      <= '0;
      pclk_ok_q        <= 1'b0;
      cur_rate_q       <= 4'd0;
      cur_pd_q         <= PD_P1;
      detect_pending_q <= 1'b0;
      det_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      counter_q        <= counter_d;
      phy_status_q     <= phy_status_d;
      rx_status_q      <= rx_status_d;
      pclk_ok_q        <= pclk_ok_d;
      cur_rate_q       <= cur_rate_d;
      cur_pd_q         <= cur_pd_d;
      detect_pending_q <= detect_pending_d;
      det_q            <= det_d;
    end
  end

  // IDLE services at most one request per visit, in rate > powerdown > detect order
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_WAIT:  if (rst_done) state_d = IDLE;
      IDLE: begin
        if (Rate != cur_rate_q)                              state_d = RATE_WAIT;
        else if (PowerDown != cur_pd_q)                      state_d = PD_WAIT;
        else if (detect_pending_q && (cur_pd_q == PD_P1))    state_d = DET_WAIT;
      end
      RATE_WAIT: if (rate_done) state_d = RATE_OK;
      RATE_OK:   if (PclkChangeAck) state_d = IDLE;
      PD_WAIT:   if (pd_done) state_d = IDLE;
      DET_WAIT:  if (det_done) state_d = IDLE;
      default:   state_d = RST_WAIT;
    endcase
    counter_d = (state_d != state_q) ? '0 : counter_q + 1'b1;
  end

  always_comb begin
    phy_status_d     = '0;
    rx_status_d      = '0;
    pclk_ok_d        = 1'b0;
    cur_rate_d       = cur_rate_q;
    cur_pd_d         = cur_pd_q;
    det_d            = TxDetectRx_Loopback;
    detect_pending_d = detect_pending_q;
    if (det_done) begin
      detect_pending_d = 1'b0;
    end else if (det_edge && (state_q != RST_WAIT)) begin
      detect_pending_d = 1'b1;
    end
    unique case (state_q)
      RST_WAIT: begin
        if (rst_done) cur_rate_d   = Rate;
        else          phy_status_d = '1;
      end
      RATE_WAIT: pclk_ok_d = rate_done;
      RATE_OK: begin
        if (PclkChangeAck) begin
          phy_status_d = '1;
          cur_rate_d   = Rate;
        end else begin
          pclk_ok_d = 1'b1;
        end
      end
      PD_WAIT: begin
        if (pd_done) begin
          phy_status_d = '1;
          cur_pd_d     = PowerDown;
        end
      end
      DET_WAIT: begin
        if (det_done) begin
          phy_status_d = '1;
          rx_status_d  = rx_result;
        end
      end
      default: ;
    endcase
  end

  assign PhyStatus     = phy_status_q;
  assign RxStatus      = rx_status_q;
  assign PclkChangeOk  = pclk_ok_q;
  assign cur_rate      = cur_rate_q;
  assign cur_powerdown = cur_pd_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_phy_ctrl_responder.sv
// Scoreboard bench for pipe_phy_ctrl_responder: each request pushes the PhyStatus
// pulse it should produce; a negedge monitor pops and compares every pulse.
module tb_pipe_phy_ctrl_responder;

  localparam int LANES   = 16;
  localparam int RST_CYC = 8;
  localparam int RATE_CY = 12;
  localparam int PD_CY   = 4;
  localparam int DET_CY  = 16;

  logic                 CLK;
  logic                 phy_reset;
  logic [3:0]           rate;
  logic [3:0]           power_down;
  logic                 tx_detect;
  logic                 pclk_ack;
  logic [LANES-1:0]     rx_mask;
  logic [LANES-1:0]     phy_status;
  logic [3*LANES-1:0]   rx_status;
  logic                 pclk_ok;
  logic [3:0]           cur_rate;
  logic [3:0]           cur_pd;
  logic                 busy;

  typedef struct {
    int             cyc;
    logic [47:0]    rx;
    logic [3:0]     rate;
    logic [3:0]     pd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  bit   prev_pulse = 0;

  pipe_phy_ctrl_responder #(
    .LANESNUMBER(LANES), .RESET_CYCLES(RST_CYC), .RATE_CYCLES(RATE_CY),
    .PD_CYCLES(PD_CY), .DETECT_CYCLES(DET_CY)
  ) dut (
    .CLK(CLK), .phy_reset(phy_reset), .Rate(rate), .PowerDown(power_down),
    .TxDetectRx_Loopback(tx_detect), .PclkChangeAck(pclk_ack),
    .rx_present_mask(rx_mask), .PhyStatus(phy_status), .RxStatus(rx_status),
    .PclkChangeOk(pclk_ok), .cur_rate(cur_rate), .cur_powerdown(cur_pd), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] pd, input logic det,
                               input logic ack, input logic [LANES-1:0] mask);
    rate       = r;
    power_down = pd;
    tx_detect  = det;
    pclk_ack   = ack;
    rx_mask    = mask;
  endtask

  function automatic logic [47:0] expRx(input logic [LANES-1:0] mask);
    logic [47:0] v = '0;
    for (int i = 0; i < LANES; i++) if (mask[i]) v[3*i +: 3] = 3'b011;
    return v;
  endfunction

  function automatic exp_t mkExp(input int c, input logic [47:0] rx, input logic [3:0] r, input logic [3:0] pd);
    exp_t e;
    e.cyc = c; e.rx = rx; e.rate = r; e.pd = pd;
    return e;
  endfunction

  // Every PhyStatus pulse outside reset must match the oldest expected entry
  always @(negedge CLK) begin
    if (mon_en) begin
      if (prev_pulse) begin
        checkOutput("pulse_width", phy_status, '0);
        checkOutput("rx_clear", rx_status, '0);
      end
      if (phy_status != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", phy_status, '0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pulse_cycle", cyc, mon_e.cyc);
          checkOutput("pulse_value", phy_status, 16'hFFFF);
          checkOutput("pulse_rxstatus", rx_status, mon_e.rx);
          checkOutput("pulse_cur_rate", cur_rate, mon_e.rate);
          checkOutput("pulse_cur_pd", cur_pd, mon_e.pd);
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic waitOkRise(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (pclk_ok) begin
        t = cyc;
        return;
      end
    end
    checkOutput("ok_timeout", pclk_ok, 1'b1);
  endtask

  task automatic waitDrain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (sb.size() == 0) break;
    end
    @(negedge CLK);
    checkOutput("sb_drain", sb.size(), 0);
  endtask

  task automatic resetRelease(input logic [3:0] exp_rate);
    repeat (3) @(negedge CLK);
    phy_reset = 1'b0;
    repeat (RST_CYC - 1) @(negedge CLK);
    checkOutput("rst_hold_phystatus", phy_status, 16'hFFFF);
    checkOutput("rst_hold_busy", busy, 1'b1);
    @(negedge CLK);
    checkOutput("rst_done_phystatus", phy_status, '0);
    checkOutput("rst_done_busy", busy, 1'b0);
    checkOutput("rst_done_cur_rate", cur_rate, exp_rate);
    mon_en = 1'b1;
  endtask

  initial begin
    int c, t_ok, a;
    logic [LANES-1:0] mask5;
    phy_reset = 1'b0;
    applyStimulus(4'd0, 4'd2, 1'b0, 1'b0, '0);
    #2 phy_reset = 1'b1;
    #1;
    checkOutput("reset_phystatus", phy_status, 16'hFFFF);
    checkOutput("reset_rxstatus", rx_status, '0);
    checkOutput("reset_ok", pclk_ok, 1'b0);
    checkOutput("reset_cur_rate", cur_rate, 4'd0);
    checkOutput("reset_cur_pd", cur_pd, 4'd2);
    checkOutput("reset_busy", busy, 1'b1);
    resetRelease(4'd0);

    $display("[TB] rate change 0->2");
    c = cyc;
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b0, '0);
    waitOkRise(40, t_ok);
    checkOutput("rate_ok_delay", t_ok - c, 1 + RATE_CY);
    checkOutput("rate_ok_busy", busy, 1'b1);
    repeat (4) begin
      @(negedge CLK);
      checkOutput("rate_ok_hold", pclk_ok, 1'b1);
    end
    a = cyc;
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b1, '0);
    sb.push_back(mkExp(a + 1, '0, 4'd2, 4'd2));
    @(negedge CLK);
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b0, '0);
    checkOutput("rate_ok_fall", pclk_ok, 1'b0);
    waitDrain(10);
    checkOutput("rate_idle_busy", busy, 1'b0);

    $display("[TB] powerdown 2->0");
    c = cyc;
    applyStimulus(4'd2, 4'd0, 1'b0, 1'b0, '0);
    sb.push_back(mkExp(c + 1 + PD_CY, '0, 4'd2, 4'd0));
    waitDrain(20);

    $display("[TB] powerdown 0->2 then receiver detect");
    c = cyc;
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b0, 16'h000F);
    sb.push_back(mkExp(c + 1 + PD_CY, '0, 4'd2, 4'd2));
    waitDrain(20);
    c = cyc;
    applyStimulus(4'd2, 4'd2, 1'b1, 1'b0, 16'h000F);
    sb.push_back(mkExp(c + 2 + DET_CY, expRx(16'h000F), 4'd2, 4'd2));
    @(negedge CLK);
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b0, 16'h000F);
    waitDrain(40);

    $display("[TB] move to P2, then simultaneous rate+powerdown with detect during RATE_OK");
    c = cyc;
    applyStimulus(4'd2, 4'd3, 1'b0, 1'b0, 16'h000F);
    sb.push_back(mkExp(c + 1 + PD_CY, '0, 4'd2, 4'd3));
    waitDrain(20);
    mask5 = 16'hA5C3;
    c = cyc;
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, mask5);
    waitOkRise(40, t_ok);
    checkOutput("combo_ok_delay", t_ok - c, 1 + RATE_CY);
    applyStimulus(4'd1, 4'd2, 1'b1, 1'b0, mask5);
    @(negedge CLK);
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, mask5);
    @(negedge CLK);
    applyStimulus(4'd1, 4'd2, 1'b1, 1'b0, mask5);
    @(negedge CLK);
    checkOutput("combo_ok_hold", pclk_ok, 1'b1);
    a = cyc;
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b1, mask5);
    sb.push_back(mkExp(a + 1, '0, 4'd1, 4'd3));
    sb.push_back(mkExp(a + 2 + PD_CY, '0, 4'd1, 4'd2));
    sb.push_back(mkExp(a + 3 + PD_CY + DET_CY, expRx(mask5), 4'd1, 4'd2));
    @(negedge CLK);
    applyStimulus(4'd1, 4'd2, 1'b0, 1'b0, mask5);
    waitDrain(60);

    $display("[TB] reset during RATE_OK");
    c = cyc;
    applyStimulus(4'd3, 4'd2, 1'b0, 1'b0, mask5);
    waitOkRise(40, t_ok);
    checkOutput("rst_mid_ok_high", pclk_ok, 1'b1);
    mon_en = 1'b0;
    @(negedge CLK);
    phy_reset = 1'b1;
    #1;
    checkOutput("rst_mid_ok", pclk_ok, 1'b0);
    checkOutput("rst_mid_cur_rate", cur_rate, 4'd0);
    checkOutput("rst_mid_phystatus", phy_status, 16'hFFFF);
    checkOutput("rst_mid_busy", busy, 1'b1);
    resetRelease(4'd3);
    @(negedge CLK);
    applyStimulus(4'd3, 4'd2, 1'b0, 1'b1, mask5);
    @(negedge CLK);
    applyStimulus(4'd3, 4'd2, 1'b0, 1'b0, mask5);
    repeat (30) @(negedge CLK);
    checkOutput("quiet_ok", pclk_ok, 1'b0);
    checkOutput("quiet_busy", busy, 1'b0);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pipe_phy_ctrl_responder.md
Name: pipe_phy_ctrl_responder

Overview:
PHY-side control responder for the PIPE interface. It answers MAC-initiated requests with the handshakes a PHY owes the MAC: reset completion, Rate change with the PCLK change handshake, PowerDown transitions and receiver detection. It drives PhyStatus, RxStatus and PclkChangeOk back onto the interface and lets the bench's PHY model emulate a compliant PHY.

Parameters:
LANESNUMBER, 16, number of lanes; all lanes respond in lockstep.
RESET_CYCLES, 8, CLK cycles after phy_reset deassertion before PhyStatus falls.
RATE_CYCLES, 12, CLK cycles from a detected Rate change to PclkChangeOk assertion.
PD_CYCLES, 4, CLK cycles from a detected PowerDown change to the PhyStatus pulse.
DETECT_CYCLES, 16, CLK cycles from a receiver-detect request to the result pulse.

Ports:
CLK  input  1  PIPE clock; all logic on the rising edge.
phy_reset  input  1  asynchronous, active-high reset.
Rate  input  4  requested rate from the MAC.
PowerDown  input  4  requested power state (lane 0 field); P0=0, P0s=1, P1=2, P2=3.
TxDetectRx_Loopback  input  1  lane 0 detect/loopback request.
PclkChangeAck  input  1  MAC acknowledge of PCLK change.
rx_present_mask  input  LANESNUMBER  bench-set mask of lanes with a receiver present.
PhyStatus  output  LANESNUMBER  PHY status, identical on all lanes.
RxStatus  output  3*LANESNUMBER  per-lane 3-bit status.
PclkChangeOk  output  1  PHY ready for PCLK change.
cur_rate  output  4  rate currently in effect.
cur_powerdown  output  4  power state currently in effect.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, phy_reset=1): state=RST_WAIT. PhyStatus all ones, RxStatus=0, PclkChangeOk=0, cur_rate=0, cur_powerdown=2 (P1), busy=1, counter=0, detect_pending=0, det_q=0.
- RST_WAIT: counter counts up after reset release. When counter reaches RESET_CYCLES-1, go to IDLE, PhyStatus=0, and load cur_rate from Rate.
- IDLE: requests are evaluated each cycle at fixed priority rate > powerdown > detect.
  - Rate != cur_rate -> RATE_WAIT.
  - PowerDown != cur_powerdown -> PD_WAIT.
  - detect_pending=1 and cur_powerdown==2 -> DET_WAIT.
  - The counter clears on every state entry.
- RATE_WAIT: after RATE_CYCLES, PclkChangeOk=1 and go to RATE_OK.
- RATE_OK: PclkChangeOk stays high until PclkChangeAck is sampled 1. In that cycle: PclkChangeOk goes to 0 next cycle, PhyStatus pulses all ones for exactly 1 cycle, cur_rate<=Rate (value at the ack), then return to IDLE.
- PclkChangeAck outside RATE_OK is ignored.
- PD_WAIT: after PD_CYCLES, PhyStatus pulses for 1 cycle, cur_powerdown<=PowerDown (value at pulse), then IDLE.
- Detect request capture:
  - det_q registers TxDetectRx_Loopback every cycle.
  - A rising edge (input=1, det_q=0) sets detect_pending. This happens in any state except RST_WAIT.
  - A new edge while already pending is absorbed; there is no double response.
- DET_WAIT: after DETECT_CYCLES, PhyStatus pulses for 1 cycle with RxStatus lane i = 3'b011 if rx_present_mask[i], else 3'b000. Clear detect_pending, then IDLE. RxStatus returns to 0 the cycle after the pulse.
- Detect requested while cur_powerdown != P1: it stays pending until P1 is in effect. No response is produced outside P1.
- Requests arriving while busy are not lost. Rate and PowerDown are compared level-wise against cur_*, and detect is latched. They are serviced in priority order on the next IDLE.
- If Rate or PowerDown returns to the cur_* value during a *_WAIT, the transaction still completes. The pulse is issued and cur_* is reloaded with the live value.
- PhyStatus pulses are exactly 1 cycle with at least 1 idle cycle between consecutive pulses. IDLE always lasts at least 1 cycle.
- Reset asserted mid-transaction aborts immediately to reset values. Pending requests are discarded.

Test Plan:
1. phy_reset high 3 cycles, then low -> PhyStatus=16'hFFFF for exactly 8 cycles after release, then 0; busy falls with it.
2. Rate 0->2 in IDLE; MAC acks 5 cycles after Ok -> PclkChangeOk rises 12 cycles after the change and stays 5 cycles. One PhyStatus=FFFF pulse follows on the ack cycle+1, and cur_rate=2.
3. PowerDown 2->0 -> 1-cycle PhyStatus pulse 4 cycles later, cur_powerdown=0; RxStatus stays 0.
4. In P1, rx_present_mask=16'h000F, TxDetectRx rises -> after 16 cycles one pulse with RxStatus lanes 0-3=3'b011, lanes 4-15=0, and all zero next cycle.
5. Rate and PowerDown changed in the same IDLE cycle, then a detect edge during RATE_OK -> rate handshake first, then PD pulse, then the detect response. Three separate pulses, no dropped request.
6. phy_reset asserted during RATE_OK -> PclkChangeOk=0 immediately and cur_rate=0. Reset sequence as in test 1 with no stale pulse afterwards.
